// File: rtl/hs_sync_pkg.sv
// hs_sync_pkg: shared state encoding, default sizes and counter width helper
package hs_sync_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'b00;
  localparam state_t VALID = 2'b01;
  localparam state_t ACK   = 2'b10;
  localparam int BUS_WIDTH_D = 5;
  localparam int TIMEOUT_D = 16;
  function automatic int cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction
endpackage

// File: rtl/hs_sync_ctrl_if.sv
// hs_sync_ctrl_if: crossing handshake, consumer and status signals
interface hs_sync_ctrl_if
  import hs_sync_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_D
) ();
  logic req_sync;
  logic [BUS_WIDTH-1:0] data_async;
  logic out_ready;
  logic err_clr;
  logic [BUS_WIDTH-1:0] data_out;
  logic data_valid;
  logic ack;
  logic busy;
  logic err;
  modport master (
    output req_sync, data_async, out_ready, err_clr,
    input data_out, data_valid, ack, busy, err
  );
  modport slave (
    input req_sync, data_async, out_ready, err_clr,
    output data_out, data_valid, ack, busy, err
  );
endinterface

// File: rtl/hs_timeout_cnt.sv
// hs_timeout_cnt: saturating counter, flags the edge on which it reaches MAX
module hs_timeout_cnt #(
  parameter int W = 4,
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  assign tc = en && (cnt == W'(MAX - 1));
  // count while enabled, hold once saturated
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en && cnt != W'(MAX)) cnt <= cnt + W'(1);
endmodule

// File: rtl/hs_sync_ctrl.sv
// hs_sync_ctrl: destination-side 4-phase req/ack capture controller
module hs_sync_ctrl
  import hs_sync_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input logic clk,
  input logic rst,
  hs_sync_ctrl_if.slave bus
);
  state_t state;
  logic [BUS_WIDTH-1:0] data_q;
  logic valid_q, ack_q, err_q, tc, viol;
  assign viol = (state == VALID && !bus.req_sync) || (state == ACK && bus.req_sync && tc);
  assign bus.data_out = data_q;
  assign bus.data_valid = valid_q;
  assign bus.ack = ack_q;
  assign bus.err = err_q;
  assign bus.busy = state != IDLE;
  hs_timeout_cnt #(.W(cnt_w(TIMEOUT)), .MAX(TIMEOUT - 1)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state != ACK),
    .en(state == ACK),
    .tc(tc)
  );
  // handshake sequencing: the bus is only sampled on the req edge seen in IDLE
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      data_q <= '0;
      valid_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (bus.req_sync) begin
            data_q <= bus.data_async;
            valid_q <= 1'b1;
            state <= VALID;
          end
        VALID:
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            ack_q <= 1'b1;
            state <= ACK;
          end
        ACK:
          if (!bus.req_sync) begin
            ack_q <= 1'b0;
            state <= IDLE;
          end
        default: begin
          valid_q <= 1'b0;
          ack_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  // sticky error, a new violation beats a simultaneous clear
  always_ff @(posedge clk)
    if (rst) err_q <= 1'b0;
    else err_q <= (err_q && !bus.err_clr) || viol;
endmodule

// File: tb/tb_hs_sync_ctrl.sv
// tb_hs_sync_ctrl: directed checks of capture, backpressure, timeout and error paths
module tb_hs_sync_ctrl;
  localparam int BW = 5;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  hs_sync_ctrl_if #(.BUS_WIDTH(BW)) bus ();
  hs_sync_ctrl #(.BUS_WIDTH(BW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input logic dv, input logic [BW-1:0] d, input logic a, input logic b, input logic e);
    chk({tag, ".valid"}, 32'(bus.data_valid), 32'(dv));
    chk({tag, ".data"}, 32'(bus.data_out), 32'(d));
    chk({tag, ".ack"}, 32'(bus.ack), 32'(a));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".err"}, 32'(bus.err), 32'(e));
  endtask
  initial begin
    rst = 1'b1;
    bus.req_sync = 1'b1;
    bus.data_async = 5'h1F;
    bus.out_ready = 1'b0;
    bus.err_clr = 1'b0;
    step();
    step();
    outs("reset", 0, 5'h00, 0, 0, 0);
    rst = 1'b0;
    step();
    outs("rel_cap", 1, 5'h1F, 0, 1, 0);
    bus.out_ready = 1'b1;
    step();
    outs("rel_ack", 0, 5'h1F, 1, 1, 0);
    bus.req_sync = 1'b0;
    step();
    outs("rel_idle", 0, 5'h1F, 0, 0, 0);
    bus.data_async = 5'b10101;
    bus.req_sync = 1'b1;
    step();
    outs("basic_cap", 1, 5'b10101, 0, 1, 0);
    step();
    outs("basic_ack", 0, 5'b10101, 1, 1, 0);
    bus.req_sync = 1'b0;
    step();
    outs("basic_idle", 0, 5'b10101, 0, 0, 0);
    bus.out_ready = 1'b0;
    bus.data_async = 5'h11;
    bus.req_sync = 1'b1;
    step();
    outs("bp_cap", 1, 5'h11, 0, 1, 0);
    bus.data_async = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      step();
      outs("bp_hold", 1, 5'h11, 0, 1, 0);
    end
    bus.out_ready = 1'b1;
    step();
    outs("bp_ack", 0, 5'h11, 1, 1, 0);
    bus.req_sync = 1'b0;
    step();
    outs("bp_idle", 0, 5'h11, 0, 0, 0);
    bus.data_async = 5'h07;
    bus.req_sync = 1'b1;
    step();
    outs("to_cap", 1, 5'h07, 0, 1, 0);
    step();
    outs("to_ack", 0, 5'h07, 1, 1, 0);
    for (int i = 1; i <= TO + 4; i++) begin
      step();
      chk($sformatf("to_err%0d", i), 32'(bus.err), 32'(i >= TO - 1));
      chk($sformatf("to_ackh%0d", i), 32'(bus.ack), 32'd1);
    end
    bus.req_sync = 1'b0;
    step();
    outs("to_idle", 0, 5'h07, 0, 0, 1);
    bus.err_clr = 1'b1;
    step();
    chk("to_clr", 32'(bus.err), 32'd0);
    bus.err_clr = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_async = 5'h12;
    bus.req_sync = 1'b1;
    step();
    outs("ed_cap", 1, 5'h12, 0, 1, 0);
    bus.req_sync = 1'b0;
    step();
    outs("ed_err", 1, 5'h12, 0, 1, 1);
    bus.out_ready = 1'b1;
    step();
    outs("ed_ack", 0, 5'h12, 1, 1, 1);
    step();
    outs("ed_idle", 0, 5'h12, 0, 0, 1);
    bus.err_clr = 1'b1;
    step();
    chk("sw_clr", 32'(bus.err), 32'd0);
    bus.out_ready = 1'b0;
    bus.data_async = 5'h05;
    bus.req_sync = 1'b1;
    step();
    outs("sw_cap", 1, 5'h05, 0, 1, 0);
    bus.req_sync = 1'b0;
    step();
    chk("sw_setwins", 32'(bus.err), 32'd1);
    bus.err_clr = 1'b0;
    bus.out_ready = 1'b1;
    step();
    outs("sw_ack", 0, 5'h05, 1, 1, 1);
    step();
    outs("sw_idle", 0, 5'h05, 0, 0, 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    bus.data_async = 5'h03;
    bus.req_sync = 1'b1;
    step();
    outs("b2b1_cap", 1, 5'h03, 0, 1, 0);
    bus.data_async = 5'h1C;
    step();
    outs("b2b1_ack", 0, 5'h03, 1, 1, 0);
    step();
    outs("b2b1_nodup", 0, 5'h03, 1, 1, 0);
    bus.req_sync = 1'b0;
    step();
    outs("b2b1_idle", 0, 5'h03, 0, 0, 0);
    bus.req_sync = 1'b1;
    step();
    outs("b2b2_cap", 1, 5'h1C, 0, 1, 0);
    step();
    outs("b2b2_ack", 0, 5'h1C, 1, 1, 0);
    bus.req_sync = 1'b0;
    step();
    outs("b2b2_idle", 0, 5'h1C, 0, 0, 0);
    bus.out_ready = 1'b0;
    bus.data_async = 5'h09;
    bus.req_sync = 1'b1;
    step();
    outs("mid_cap", 1, 5'h09, 0, 1, 0);
    rst = 1'b1;
    step();
    outs("mid_rst", 0, 5'h00, 0, 0, 0);
    rst = 1'b0;
    bus.req_sync = 1'b0;
    step();
    outs("mid_idle", 0, 5'h00, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hs_sync_ctrl.md
# hs_sync_ctrl

Destination-domain controller for a 4-phase req/ack multi-bit crossing. It consumes the synchronized request from a bit synchronizer and captures the source-held data bus. It presents the captured word to the local consumer with valid/ready, then drives ack back to the source domain through a return synchronizer. It sequences the synchronizer datapath so that a multi-bit bus is sampled only when it is guaranteed stable.

## Interface
Parameters:
- BUS_WIDTH, 5, width of crossed data bus
- TIMEOUT, 16, max cycles in ACK waiting for req_sync to fall before err is flagged (≥2)

Ports:
- clk  in  1  single clock, destination domain
- rst  in  1  synchronous, active-high reset
- req_sync  in  1  source request after bit synchronizer (level, 4-phase)
- data_async  in  BUS_WIDTH  source data bus, held stable by source while req high
- out_ready  in  1  consumer ready
- err_clr  in  1  clears sticky err
- data_out  out  BUS_WIDTH  captured word, registered
- data_valid  out  1  captured word available
- ack  out  1  acknowledge to source domain, registered
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky protocol/timeout error

## Operation
- Reset values: state=IDLE, data_out=0, data_valid=0, ack=0, err=0, timeout counter=0; busy=0.
- IDLE:
  - ack=0, data_valid=0.
  - req_sync=1 sampled → data_out<=data_async, data_valid<=1, go VALID.
- VALID:
  - data_valid held high, data_out frozen until data_valid&&out_ready at an edge.
  - At that edge: data_valid<=0, ack<=1, counter<=0, go ACK.
  - req_sync=0 sampled while in VALID (source dropped early) → err<=1; transfer still completes normally.
- ACK:
  - ack held 1; counter increments each cycle, saturating at TIMEOUT-1.
  - req_sync=0 sampled → ack<=0, go IDLE.
  - Counter reaching TIMEOUT-1 with req_sync still 1 → err<=1, remain in ACK (ack stays high) until req_sync falls.
- IDLE re-entry requires req_sync low first (guaranteed by ACK exit), so one req pulse yields exactly one data_valid transfer.
- err: set by either violation, cleared only by err_clr=1 or rst. Set and clear in the same cycle → set wins.
- busy = (state != IDLE), combinational from state register.
- rst mid-transaction: immediate return to reset values on the next edge; an in-flight word is dropped, and ack falling signals abort to the source.

## Timing
- req_sync rises sampled at edge n → data_valid=1 and data_out valid after edge n.
- out_ready=1 at edge m (m≥n+1) → data_valid=0, ack=1 after edge m.
- Best case (out_ready tied 1): data_valid high exactly 1 cycle; ack rises 1 cycle after data_valid.
- req_sync sampled low at edge k in ACK → ack=0 after edge k; new request accepted no earlier than edge k+1.
- err asserts the edge after the violating sample; timeout fires TIMEOUT-1 cycles after entering ACK.
- No combinational path from any input to any output.

## Structure
- Shared package hs_sync_pkg:
  - state typedef, 2-bit: IDLE=2'b00, VALID=2'b01, ACK=2'b10; 2'b11 illegal, recovers to IDLE.
  - Default BUS_WIDTH/TIMEOUT constants.
  - Counter width function clog2(TIMEOUT).
- Sub-module hs_timeout_cnt: saturating counter with sync clear/enable and terminal-count flag; instantiated once.
- The request and ack bit synchronizers live outside this block at top level.

## Test plan
- Reset: rst=1 for 2 cycles with req_sync=1 → all outputs 0, state IDLE. Release → one capture proceeds.
- Basic transfer: data_async=5'b10101, req_sync rises, out_ready=1 → data_out=5'b10101 with data_valid for 1 cycle, ack next cycle. Drop req_sync → ack low 1 cycle later, busy=0.
- Backpressure: out_ready=0 for 5 cycles after capture → data_valid high 6 cycles, data_out stable even when data_async changes to 5'b01010, ack stays 0 until ready.
- Timeout: hold req_sync=1 for TIMEOUT+4 cycles in ACK → err=1 at cycle TIMEOUT-1, ack held. Drop req → IDLE. Pulse err_clr → err=0.
- Early req drop: req_sync falls while VALID → err=1, transfer still completes, ack pulses 1 cycle.
- Back-to-back: two requests with data 5'h03 then 5'h1C → exactly two data_valid transfers in order, no duplicate capture.
